// File: rtl/sensor_sample_fifo_pkg.sv
// sensor_fifo_pkg
//   Shared constants and types for the sensor sample FIFO.
//   DW_SAMPLE     : width of one filtered sensor sample
//   DEPTH_DEFAULT : default number of buffered samples
//   sample_t      : signed sample as produced by the filter chain
package sensor_fifo_pkg;

  localparam int DW_SAMPLE     = 16;
  localparam int DEPTH_DEFAULT = 16;

  typedef logic signed [DW_SAMPLE-1:0] sample_t;

endpackage

// File: rtl/sensor_sample_fifo_if.sv
// sensor_sample_fifo_if
//   Bundles the producer, reader and status signals of the sample FIFO.
//   master : filter chain / host side (drives writes, read requests, control)
//   slave  : the FIFO itself
//   Signals:
//     clear_fifo, overflow_clr   synchronous control strobes
//     data_in_valid, data_in     sample strobe and sample
//     watermark                  irq threshold (0 disables)
//     rd_req, rd_data, rd_valid  read request and registered read response
//     level, full, empty         occupancy status
//     overflow, irq              sticky drop flag and watermark interrupt
interface sensor_sample_fifo_if
  import sensor_fifo_pkg::*;
#(
  parameter int DW = DW_SAMPLE,
  parameter int AW = $clog2(DEPTH_DEFAULT)
);

  logic          clear_fifo;
  logic          data_in_valid;
  logic [DW-1:0] data_in;
  logic [AW:0]   watermark;
  logic          rd_req;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic [AW:0]   level;
  logic          full;
  logic          empty;
  logic          overflow;
  logic          overflow_clr;
  logic          irq;

  modport master (
    output clear_fifo, data_in_valid, data_in, watermark, rd_req, overflow_clr,
    input  rd_data, rd_valid, level, full, empty, overflow, irq
  );

  modport slave (
    input  clear_fifo, data_in_valid, data_in, watermark, rd_req, overflow_clr,
    output rd_data, rd_valid, level, full, empty, overflow, irq
  );

endinterface

// File: rtl/sensor_sample_fifo_ram.sv
// sensor_fifo_ram
//   Simple dual-port sample storage: one write port, one registered read port.
//   Ports:
//     clk, rstx           clock, asynchronous active-low reset (read register only)
//     wr_en/wr_addr/wr_data  write port
//     rd_en/rd_addr       read port; rd_data updates the cycle after rd_en
//     rd_data             registered read data, holds when rd_en is low
module sensor_fifo_ram #(
  parameter int DEPTH = 16,
  parameter int DW    = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rstx,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem [DEPTH];

  // Storage itself carries no reset so it can map onto RAM resources.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read-before-write: a read and write to the same slot in one cycle
  // returns the old contents, which is what a full FIFO doing both needs.
  always_ff @(posedge clk or negedge rstx) begin
    if (!rstx) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/sensor_sample_fifo.sv
// sensor_sample_fifo
//   Buffers filtered sensor samples for a slower host reader.
//   Ports:
//     clk   system clock
//     rstx  asynchronous active-low reset
//     bus   sensor_sample_fifo_if.slave: write strobe/data, read request and
//           registered response, level/full/empty, sticky overflow,
//           watermark irq, flush and overflow-clear controls
//   Reads have one cycle of latency and never fall through: a sample written
//   in the same cycle as a read of an empty FIFO is returned by a later read.
module sensor_sample_fifo
  import sensor_fifo_pkg::*;
#(
  parameter  int DEPTH = DEPTH_DEFAULT,
  parameter  int DW    = DW_SAMPLE,
  localparam int AW    = $clog2(DEPTH)
) (
  input logic                 clk,
  input logic                 rstx,
  sensor_sample_fifo_if.slave bus
);

  localparam logic [AW:0] DEPTH_LVL = (AW+1)'(DEPTH);

  logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [AW:0]   level_reg, level_next;
  logic          overflow_reg, overflow_next;
  logic          irq_reg, irq_next;
  logic          rd_valid_reg;
  logic          full, empty;
  logic          rd_ok, wr_ok, drop;

  // Level is the only source of full/empty; pointers alone are ambiguous
  // when equal.
  assign full  = (level_reg == DEPTH_LVL);
  assign empty = (level_reg == '0);

  always_comb begin
    rd_ok         = 1'b0;
    wr_ok         = 1'b0;
    drop          = 1'b0;
    wr_ptr_next   = wr_ptr_reg;
    rd_ptr_next   = rd_ptr_reg;
    level_next    = level_reg;
    overflow_next = overflow_reg;
    irq_next      = 1'b0;

    if (bus.clear_fifo) begin
      // Flush overrides any same-cycle write or read.
      wr_ptr_next   = '0;
      rd_ptr_next   = '0;
      level_next    = '0;
      overflow_next = 1'b0;
    end else begin
      rd_ok = bus.rd_req && !empty;
      // A read accepted in the same cycle frees a slot for a full FIFO.
      wr_ok = bus.data_in_valid && (!full || rd_ok);
      drop  = bus.data_in_valid && !wr_ok;

      if (wr_ok) wr_ptr_next = wr_ptr_reg + AW'(1);
      if (rd_ok) rd_ptr_next = rd_ptr_reg + AW'(1);

      if (wr_ok && !rd_ok) begin
        level_next = level_reg + (AW+1)'(1);
      end else if (rd_ok && !wr_ok) begin
        level_next = level_reg - (AW+1)'(1);
      end

      // A new drop wins over a same-cycle clear request.
      if (drop) begin
        overflow_next = 1'b1;
      end else if (bus.overflow_clr) begin
        overflow_next = 1'b0;
      end

      // level never exceeds DEPTH, so a watermark above DEPTH never fires.
      irq_next = (bus.watermark != '0) && (level_next >= bus.watermark);
    end
  end

  always_ff @(posedge clk or negedge rstx) begin
    if (!rstx) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      level_reg    <= '0;
      overflow_reg <= 1'b0;
      irq_reg      <= 1'b0;
      rd_valid_reg <= 1'b0;
    end else begin
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
      level_reg    <= level_next;
      overflow_reg <= overflow_next;
      irq_reg      <= irq_next;
      rd_valid_reg <= rd_ok;
    end
  end

  sensor_fifo_ram #(
    .DEPTH (DEPTH),
    .DW    (DW),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .rstx    (rstx),
    .wr_en   (wr_ok),
    .wr_addr (wr_ptr_reg),
    .wr_data (bus.data_in),
    .rd_en   (rd_ok),
    .rd_addr (rd_ptr_reg),
    .rd_data (bus.rd_data)
  );

  assign bus.rd_valid = rd_valid_reg;
  assign bus.level    = level_reg;
  assign bus.full     = full;
  assign bus.empty    = empty;
  assign bus.overflow = overflow_reg;
  assign bus.irq      = irq_reg;

endmodule

// File: doc/sensor_sample_fifo.md
Name: sensor_sample_fifo

Overview:
- Buffers the 16-bit filtered sensor samples (data_out/data_out_valid) produced by the decimation/IIR/scale/noise-gate chain.
- Lets a slower host-side reader drain samples at its own pace.
- Provides a level count, full/empty flags, a sticky overflow flag and a watermark interrupt.
- Sits directly downstream of the sensor filter chain on the same clock.

Parameters:
- DEPTH, 16: number of sample entries; power of two, 4..256.
- DW, 16: sample width; matches the filter chain output.
- AW, $clog2(DEPTH): pointer width (derived, not overridden).

Ports:
- clk  in  1  system clock.
- rstx  in  1  asynchronous active-low reset.
- clear_fifo  in  1  synchronous flush: empties FIFO, clears overflow.
- data_in_valid  in  1  one-cycle strobe, sample present on data_in.
- data_in  in  DW  signed sample from the filter chain.
- watermark  in  AW+1  irq threshold in entries; 0 disables irq.
- rd_req  in  1  pop request, one entry per asserted cycle.
- rd_data  out  DW  popped sample.
- rd_valid  out  1  rd_data valid; one-cycle pulse.
- level  out  AW+1  current number of stored entries, 0..DEPTH.
- full  out  1  level == DEPTH.
- empty  out  1  level == 0.
- overflow  out  1  sticky: a sample was dropped.
- overflow_clr  in  1  clears overflow.
- irq  out  1  level >= watermark and watermark != 0.

Behaviour:
- Reset (rstx=0, async):
  - wr_ptr, rd_ptr and level = 0; empty=1, full=0.
  - overflow=0, irq=0, rd_valid=0, rd_data=0.
  - Memory contents are don't-care.
- Write:
  - data_in_valid=1 and not full: store at wr_ptr, wr_ptr+1 (wraps mod DEPTH).
  - data_in_valid=1 and full: sample dropped, overflow set next cycle. Exception: a same-cycle accepted read frees a slot, and then the write is accepted.
- Read:
  - rd_req=1 and not empty: rd_data/rd_valid registered, visible in the cycle after rd_req (latency 1); rd_ptr+1 (wraps).
  - rd_req=1 and empty: ignored, rd_valid=0, rd_data holds its previous value.
  - No fall-through: a write and a read to an empty FIFO in the same cycle returns nothing that cycle; the sample is readable on the next rd_req.
- Level update, registered:
  - write only: +1.
  - read only: −1.
  - both accepted: unchanged.
- Flags:
  - full and empty are decoded combinationally from registered level.
  - Pointers are AW bits; level is the sole full/empty source.
- irq:
  - Registered; irq <= (watermark != 0) && (level_next >= watermark).
  - Tracks level with 1-cycle latency relative to the causing write/read.
  - Level-sensitive; deasserts when the FIFO is drained below watermark.
  - watermark > DEPTH: irq never asserts.
- overflow:
  - Set by a dropped write; cleared by overflow_clr.
  - Set wins over a same-cycle overflow_clr.
- clear_fifo:
  - Next cycle: pointers and level = 0, overflow=0, irq=0, rd_valid=0.
  - Overrides a same-cycle write and read; neither is performed.
- Reset mid-operation: all state returns to reset values immediately; buffered samples are lost.
- Arithmetic: no sign handling inside the FIFO; data is passed bit-exact.

Decomposition:
- Package sensor_fifo_pkg holds DW_SAMPLE=16, typedef logic signed [15:0] sample_t, and the default DEPTH constant.
- One natural sub-module, sensor_fifo_ram: a simple dual-port register array with one write port and one registered read port.
- All pointer, level, flag and irq logic lives in sensor_sample_fifo.

Test Plan:
- Fill and drain: reset, write 0x0001..0x0010 (16 samples), then rd_req for 16 cycles.
  - During fill, level goes 0→16 and full=1 after the 16th write.
  - Reads return 0x0001..0x0010 in order, each rd_valid one cycle after rd_req; empty=1 at end.
- Overflow: with the FIFO full, write 0x7FFF.
  - Sample dropped; level stays 16; overflow=1.
  - Next read returns 0x0001.
  - overflow_clr clears the flag; overflow stays 0 afterwards.
- Simultaneous read/write when full: rd_req and write 0x8000 in the same cycle.
  - level stays 16; overflow stays 0.
  - 0x8000 is read out last.
- Watermark: watermark=4; write 4 samples.
  - irq rises the cycle after the 4th write.
  - One read drops irq the cycle after.
  - watermark=0 keeps irq=0 throughout.
- Empty read and no fall-through: rd_req on an empty FIFO gives rd_valid=0.
  - A same-cycle write of 0x1234 with rd_req on an empty FIFO gives rd_valid=0.
  - The next rd_req returns 0x1234.
- Clear and async reset: with level=10, assert clear_fifo together with a write and a read.
  - Next cycle level=0 and empty=1.
  - Refill 5 samples, pulse rstx low mid-cycle: all outputs reach reset values without a clock edge.
